red_part1_row_accum_43: RTL and testbench

//  Sink for the flattened partial-product bus of the Montgomery reduction, step 1.
//  The bus holds 43 rows in carry-save form (c and s). Row i sits at bits [43*i+42 : 43*i]
//  and is already shifted and gated by p_prime[i].
//  The block sums all 86 words modulo 2^43 over several cycles and returns q = (a*p') mod 2^43
//  to the reduction datapath, using a valid/ready handshake on both sides.

---
 rtl/red_part1_row_accum_43.sv | 159 +++++++++++++++
 tb/tb_red_part1_row_accum_43.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/red_part1_row_accum_43.sv
// Montgomery step-1 row accumulator: folds 43 carry-save rows of a*p' into
// q = (a*p') mod 2^W over several cycles. Optional macro RED_ROW_ACCUM_CS_OUT_EN.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   operand handshake for rows_c/rows_s
//   rows_c, rows_s      flattened carry/sum rows, row i at [W*i +: W]
//   out_valid/out_ready result handshake
//   q                   resolved sum mod 2^W (0 when carry-save output is on)
//   q_c, q_s            carry-save result, only with RED_ROW_ACCUM_CS_OUT_EN
module red_part1_row_accum_43 #(
  parameter int W            = 43,
  parameter int ROWS         = 43,
  parameter int ROWS_PER_CYC = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W*ROWS-1:0]   rows_c,
  input  logic [W*ROWS-1:0]   rows_s,
  output logic                out_valid,
  input  logic                out_ready,
`ifdef RED_ROW_ACCUM_CS_OUT_EN
  output logic [W-1:0]        q_c,
  output logic [W-1:0]        q_s,
`endif
  output logic [W-1:0]        q
);

  localparam int CW = $clog2(ROWS + ROWS_PER_CYC + 1);
  localparam logic [CW-1:0] LP_STEP = CW'(ROWS_PER_CYC);
  localparam logic [CW-1:0] LP_ROWS = CW'(ROWS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]    r_state;
  logic [W-1:0]  r_op_c [ROWS];
  logic [W-1:0]  r_op_s [ROWS];
  logic [W-1:0]  r_acc_c;
  logic [W-1:0]  r_acc_s;
  logic [CW-1:0] r_row_cnt;
  logic          r_out_valid;

  logic [W-1:0]  w_c;
  logic [W-1:0]  w_s;
  logic [W-1:0]  w_wc;
  logic [W-1:0]  w_ws;
  logic [W-1:0]  w_t;
  logic [CW-1:0] w_idx;
  logic [CW-1:0] w_next_cnt;

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = r_out_valid;
  assign w_next_cnt = r_row_cnt + LP_STEP;

  // Operand store has no reset: it is always rewritten before use.
  always_ff @(posedge clk) begin
    if (in_valid && (r_state == S_IDLE)) begin
      for (int i = 0; i < ROWS; i++) begin
        r_op_c[i] <= rows_c[i*W +: W];
        r_op_s[i] <= rows_s[i*W +: W];
      end
    end
  end

  // Chain of 3:2 compressors: each row contributes two words.
  // Rows past the end of the bus read as zero.
  always_comb begin
    w_c  = r_acc_c;
    w_s  = r_acc_s;
    w_wc = '0;
    w_ws = '0;
    w_t  = '0;
    w_idx = '0;
    for (int k = 0; k < ROWS_PER_CYC; k++) begin
      w_idx = r_row_cnt + CW'(k);
      if (w_idx < LP_ROWS) begin
        w_wc = r_op_c[w_idx];
        w_ws = r_op_s[w_idx];
      end else begin
        w_wc = '0;
        w_ws = '0;
      end
      w_t = w_s ^ w_c ^ w_wc;
      w_c = ((w_s & w_c) | (w_s & w_wc) | (w_c & w_wc)) << 1;
      w_s = w_t;
      w_t = w_s ^ w_c ^ w_ws;
      w_c = ((w_s & w_c) | (w_s & w_ws) | (w_c & w_ws)) << 1;
      w_s = w_t;
    end
  end

`ifdef RED_ROW_ACCUM_CS_OUT_EN
  assign q_c = r_acc_c;
  assign q_s = r_acc_s;
  assign q   = '0;
`else
  logic [W-1:0] r_q;
  assign q = r_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_acc_c     <= '0;
      r_acc_s     <= '0;
      r_row_cnt   <= '0;
`ifndef RED_ROW_ACCUM_CS_OUT_EN
      r_q         <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_acc_c   <= '0;
            r_acc_s   <= '0;
            r_row_cnt <= '0;
            r_state   <= S_ACC;
          end
        end
        S_ACC: begin
          r_acc_c   <= w_c;
          r_acc_s   <= w_s;
          r_row_cnt <= w_next_cnt;
          if (w_next_cnt >= LP_ROWS) begin
`ifdef RED_ROW_ACCUM_CS_OUT_EN
            r_out_valid <= 1'b1;
            r_state     <= S_HOLD;
`else
            r_state     <= S_FIN;
`endif
          end
        end
        S_FIN: begin
`ifdef RED_ROW_ACCUM_CS_OUT_EN
          r_state     <= S_IDLE;
`else
          r_q         <= r_acc_c + r_acc_s;
          r_out_valid <= 1'b1;
          r_state     <= S_HOLD;
`endif
        end
        S_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_red_part1_row_accum_43.sv
// Directed/random bench for red_part1_row_accum_43 at ROWS_PER_CYC 1, 4, 43.
// Expected results come from (a_c+a_s)*p' mod 2^43 computed here.
module tb_red_part1_row_accum_43;

  localparam int W = 43;
  localparam int R = 43;

`ifdef RED_ROW_ACCUM_CS_OUT_EN
  localparam int L1 = 43;
  localparam int L2 = 11;
  localparam int L3 = 1;
`else
  localparam int L1 = 44;
  localparam int L2 = 12;
  localparam int L3 = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [W*R-1:0] rows_c = '0;
  logic [W*R-1:0] rows_s = '0;

  logic ir1, ir2, ir3, ov1, ov2, ov3;
  logic [W-1:0] q1, q2, q3, r1, r2, r3;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

`ifdef RED_ROW_ACCUM_CS_OUT_EN
  logic [W-1:0] qc1, qs1, qc2, qs2, qc3, qs3;
  assign r1 = qc1 + qs1;
  assign r2 = qc2 + qs2;
  assign r3 = qc3 + qs3;
`define CSP(a, b) .q_c(a), .q_s(b),
`else
  assign r1 = q1;
  assign r2 = q2;
  assign r3 = q3;
`define CSP(a, b)
`endif

  red_part1_row_accum_43 #(.ROWS_PER_CYC(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
    .rows_c(rows_c), .rows_s(rows_s), .out_valid(ov1),
    .out_ready(out_ready), `CSP(qc1, qs1) .q(q1));
  red_part1_row_accum_43 #(.ROWS_PER_CYC(4)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2),
    .rows_c(rows_c), .rows_s(rows_s), .out_valid(ov2),
    .out_ready(out_ready), `CSP(qc2, qs2) .q(q2));
  red_part1_row_accum_43 #(.ROWS_PER_CYC(43)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir3),
    .rows_c(rows_c), .rows_s(rows_s), .out_valid(ov3),
    .out_ready(out_ready), `CSP(qc3, qs3) .q(q3));

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic build(input logic [W-1:0] ac, input logic [W-1:0] as_,
                       input logic [W-1:0] p);
    logic [W-1:0] tc, ts;
    for (int i = 0; i < R; i++) begin
      tc = ac << i;
      ts = as_ << i;
      rows_c[i*W +: W] = p[i] ? tc : '0;
      rows_s[i*W +: W] = p[i] ? ts : '0;
    end
  endtask

  task automatic run_op(input logic [W-1:0] ac, input logic [W-1:0] as_,
                        input logic [W-1:0] p, input int hold);
    logic [W-1:0] exp, sum;
    int lat1, lat2, lat3;
    logic [W-1:0] g1, g2, g3;
    sum = ac + as_;
    exp = sum * p;
    lat1 = 0; lat2 = 0; lat3 = 0;
    g1 = '0; g2 = '0; g3 = '0;
    @(negedge clk);
    build(ac, as_, p);
    chk("in_ready_idle", {63'd0, ir1}, 64'd1);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (lat1 != 0 && lat2 != 0 && lat3 != 0) break;
      @(posedge clk);
      #1;
      if (ov1 && lat1 == 0) begin lat1 = cyc; g1 = r1; end
      if (ov2 && lat2 == 0) begin lat2 = cyc; g2 = r2; end
      if (ov3 && lat3 == 0) begin lat3 = cyc; g3 = r3; end
    end
    chk("lat_rpc1", lat1, L1);
    chk("lat_rpc4", lat2, L2);
    chk("lat_rpc43", lat3, L3);
    chk("q_rpc1", g1, exp);
    chk("q_rpc4", g2, exp);
    chk("q_rpc43", g3, exp);
    for (int h = 0; h < hold; h++) begin
      in_valid = h[0];
      rows_c = {R{W'($urandom)}};
      @(posedge clk);
      #1;
      chk("hold_valid", {63'd0, ov1}, 64'd1);
      chk("hold_ready", {63'd0, ir1}, 64'd0);
      chk("hold_q", r1, exp);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("drop_valid", {61'd0, ov1, ov2, ov3}, 64'd0);
    chk("back_ready", {61'd0, ir1, ir2, ir3}, 64'd7);
  endtask

  logic [W-1:0] ra, rb, rp;

  initial begin
    #12;
    chk("rst_ready", {61'd0, ir1, ir2, ir3}, 64'd7);
    chk("rst_valid", {61'd0, ov1, ov2, ov3}, 64'd0);
    chk("rst_q", r1, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset during accumulation
    @(negedge clk);
    build(43'h123456789, 43'h55, 43'h7abcdef0123);
    out_ready = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", {61'd0, ir1, ir2, ir3}, 64'd7);
    chk("midrst_valid", {61'd0, ov1, ov2, ov3}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(43'h123456789, 43'h55, 43'h7abcdef0123, 0);

    // single bit in row 0 carry word
    run_op(43'd1, 43'd0, 43'd1, 0);
    // all-ones times all-ones wraps to 1
    run_op({W{1'b1}}, 43'd0, {W{1'b1}}, 0);
    // zero p' gives zero
    run_op({W{1'b1}}, {W{1'b1}}, 43'd0, 0);
    // long hold with ignored in_valid pulses
    run_op(43'h4aaaaaaaaaa, 43'h3f0f0f0f0f0, 43'h5555555555b, 20);

    for (int v = 0; v < 1000; v++) begin
      ra = W'({$urandom, $urandom});
      rb = W'({$urandom, $urandom});
      rp = W'({$urandom, $urandom});
      run_op(ra, rb, rp, 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
